// File: rtl/dot_product_seq_pkg.sv
// Shared definitions for the dot_product_seq slice.
//   state_t       : sequencer FSM states
//   OPND_W        : operand width of one lane
//   CHUNK_SUM_W   : width of one 4-lane chunk sum (4 x 15 x 15 = 900 < 2^10)
//   LEN_W_DEFAULT : default width of the chunk-count field
package dot_product_seq_pkg;

    localparam int unsigned OPND_W        = 4;
    localparam int unsigned CHUNK_SUM_W   = 10;
    localparam int unsigned LEN_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dot_product_seq_dot4_pipe.sv
// dot4_pipe: 4-stage 4-lane multiply/add-tree.
//   Stage 1 registers the operands, stage 2 the four 8b lane products,
//   stage 3 the two 9b pair sums, stage 4 the 10b chunk sum.
//   A chunk presented with valid_in at edge k shows valid_out after edge k+3.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   valid_in, last_in     tags travelling with the chunk
//   a_in..d_in            left operands
//   e_in..h_in            right operands (pairs a*e, b*f, c*g, d*h)
//   valid_out, last_out   tags aligned with sum_out
//   sum_out               chunk sum
module dot4_pipe
    import dot_product_seq_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   valid_in,
    input  logic                   last_in,
    input  logic [OPND_W-1:0]      a_in,
    input  logic [OPND_W-1:0]      b_in,
    input  logic [OPND_W-1:0]      c_in,
    input  logic [OPND_W-1:0]      d_in,
    input  logic [OPND_W-1:0]      e_in,
    input  logic [OPND_W-1:0]      f_in,
    input  logic [OPND_W-1:0]      g_in,
    input  logic [OPND_W-1:0]      h_in,
    output logic                   valid_out,
    output logic                   last_out,
    output logic [CHUNK_SUM_W-1:0] sum_out
);

    logic [3:0]                   vld_q, vld_d;
    logic [3:0]                   lst_q, lst_d;
    logic [3:0][OPND_W-1:0]       lop_q, lop_d;
    logic [3:0][OPND_W-1:0]       rop_q, rop_d;
    logic [3:0][2*OPND_W-1:0]     prod_q, prod_d;
    logic [1:0][2*OPND_W:0]       pair_q, pair_d;
    logic [CHUNK_SUM_W-1:0]       sum_q, sum_d;

    always_comb begin
        // Tag shift registers: bit i is the tag of stage i+1.
        vld_d = {vld_q[2:0], valid_in};
        lst_d = {lst_q[2:0], last_in};
        lop_d = {d_in, c_in, b_in, a_in};
        rop_d = {h_in, g_in, f_in, e_in};
        prod_d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            prod_d[i] = {{OPND_W{1'b0}}, lop_q[i]} * {{OPND_W{1'b0}}, rop_q[i]};
        end
        pair_d[0] = {1'b0, prod_q[0]} + {1'b0, prod_q[1]};
        pair_d[1] = {1'b0, prod_q[2]} + {1'b0, prod_q[3]};
        sum_d     = {1'b0, pair_q[0]} + {1'b0, pair_q[1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q  <= '0;
            lst_q  <= '0;
            lop_q  <= '0;
            rop_q  <= '0;
            prod_q <= '0;
            pair_q <= '0;
            sum_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            lst_q  <= lst_d;
            lop_q  <= lop_d;
            rop_q  <= rop_d;
            prod_q <= prod_d;
            pair_q <= pair_d;
            sum_q  <= sum_d;
        end
    end

    assign valid_out = vld_q[3];
    assign last_out  = lst_q[3];
    assign sum_out   = sum_q;

endmodule

// File: rtl/dot_product_seq.sv
// dot_product_seq: accepts a job of i_len+1 four-lane chunks, streams them
// through dot4_pipe and accumulates the chunk sums into one result.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_len               job request and chunk count minus 1
//   o_busy                       start accepted, result not yet taken
//   i_in_valid, o_in_ready       chunk handshake
//   i_a..i_d, i_e..i_h           chunk operands
//   o_out_valid, i_out_ready     result handshake
//   o_out                        dot product (held after hand-off)
module dot_product_seq
    import dot_product_seq_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEFAULT,
    parameter int unsigned ACC_W = CHUNK_SUM_W + LEN_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [OPND_W-1:0] i_a,
    input  logic [OPND_W-1:0] i_b,
    input  logic [OPND_W-1:0] i_c,
    input  logic [OPND_W-1:0] i_d,
    input  logic [OPND_W-1:0] i_e,
    input  logic [OPND_W-1:0] i_f,
    input  logic [OPND_W-1:0] i_g,
    input  logic [OPND_W-1:0] i_h,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ACC_W-1:0]  o_out
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   out_q, out_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic                   accept;
    logic                   last_accept;
    logic                   pipe_valid;
    logic                   pipe_last;
    logic [CHUNK_SUM_W-1:0] pipe_sum;
    logic [ACC_W-1:0]       sum_ext;

    // in_ready_q is high exactly in FEED, so it doubles as the state qualifier.
    assign accept      = i_in_valid & in_ready_q;
    assign last_accept = accept & (remaining_q == '0);
    assign sum_ext     = {{(ACC_W-CHUNK_SUM_W){1'b0}}, pipe_sum};

    dot4_pipe u_pipe (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .valid_in  (accept),
        .last_in   (last_accept),
        .a_in      (i_a),
        .b_in      (i_b),
        .c_in      (i_c),
        .d_in      (i_d),
        .e_in      (i_e),
        .f_in      (i_f),
        .g_in      (i_g),
        .h_in      (i_h),
        .valid_out (pipe_valid),
        .last_out  (pipe_last),
        .sum_out   (pipe_sum)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        out_d       = out_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        // Chunk results are still emerging in DRAIN while earlier ones
        // may emerge during FEED; every valid one is added exactly once.
        if (pipe_valid && (state_q == FEED || state_q == DRAIN)) begin
            acc_d = acc_q + sum_ext;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = FEED;
                    remaining_d = i_len;
                    acc_d       = '0;
                    busy_d      = 1'b1;
                    in_ready_d  = 1'b1;
                end
            end
            FEED: begin
                if (accept) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == '0) begin
                        state_d    = DRAIN;
                        in_ready_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (pipe_valid && pipe_last) begin
                    state_d     = DONE;
                    out_d       = acc_q + sum_ext;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_in_ready  = in_ready_q;
    assign o_out_valid = out_valid_q;
    assign o_out       = out_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench for dot_product_seq: directed scenarios plus random
// jobs, checked every cycle against a job-level behavioural model.
module tb_dot_product_seq;

    localparam int LEN_W = 4;
    localparam int ACC_W = 10 + LEN_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a, b, c, d, e, f, g, h;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out;

    dot_product_seq #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_len       (len),
        .o_busy      (busy),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_c         (c),
        .i_d         (d),
        .i_e         (e),
        .i_f         (f),
        .i_g         (g),
        .i_h         (h),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Job-level model: expected result is the plain sum of lane products of
    // every accepted chunk; the result is due 4 edges after the last accept.
    int  edge_n     = 0;
    bit  m_busy     = 0;
    bit  m_feed     = 0;
    bit  m_pending  = 0;
    int  m_left     = 0;
    int  m_acc      = 0;
    int  m_out      = 0;
    int  m_due_edge = 0;

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic bit exp_valid();
        return m_pending && (edge_n >= m_due_edge);
    endfunction

    task automatic check_outputs();
        cmp("o_busy", busy, m_busy);
        cmp("o_in_ready", in_ready, m_feed);
        cmp("o_out_valid", out_valid, exp_valid());
        if (exp_valid())
            cmp("o_out_result", out, m_acc);
        else if (!m_busy)
            cmp("o_out_idle_hold", out, m_out);
    endtask

    // One clock: update the model from the inputs sampled at the edge,
    // then compare on the falling edge.
    task automatic tick();
        bit was_valid;
        was_valid = exp_valid();
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_busy = 0; m_feed = 0; m_pending = 0; m_out = 0; m_acc = 0;
        end else if (was_valid && out_ready) begin
            m_busy = 0; m_pending = 0; m_out = m_acc;
        end else if (!m_busy && start) begin
            m_busy = 1; m_feed = 1; m_left = int'(len) + 1; m_acc = 0;
        end else if (m_feed && in_valid) begin
            m_acc += int'(a)*int'(e) + int'(b)*int'(f) + int'(c)*int'(g) + int'(d)*int'(h);
            m_left--;
            if (m_left == 0) begin
                m_feed = 0; m_pending = 1; m_due_edge = edge_n + 4;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    // mode 0: random, 1: 1..4 x 5..8, 2: all 15, 3: all lanes 2*3
    task automatic set_ops(input int mode);
        case (mode)
            1: begin a = 1; b = 2; c = 3; d = 4; e = 5; f = 6; g = 7; h = 8; end
            2: begin a = 15; b = 15; c = 15; d = 15; e = 15; f = 15; g = 15; h = 15; end
            3: begin a = 2; b = 2; c = 2; d = 2; e = 3; f = 3; g = 3; h = 3; end
            default: begin
                a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
                e = 4'($urandom); f = 4'($urandom); g = 4'($urandom); h = 4'($urandom);
            end
        endcase
    endtask

    task automatic do_job(input int jlen, input int mode, input int gap_min, input int gap_max,
                          input int bp, input bit start_in_done, input bit chk_lat,
                          output int result);
        int n;
        start = 1; len = LEN_W'(jlen);
        tick();
        start = 0;
        for (int ci = 0; ci <= jlen; ci++) begin
            in_valid = 0;
            repeat ($urandom_range(gap_max, gap_min)) tick();
            set_ops(mode);
            in_valid = 1;
            tick();
            in_valid = 0;
        end
        cmp("in_ready_after_last", in_ready, 0);
        if (chk_lat) begin
            for (int i = 1; i <= 3; i++) begin
                tick();
                cmp("out_valid_before_k4", out_valid, 0);
            end
            tick();
            cmp("out_valid_at_k4", out_valid, 1);
        end
        n = 0;
        while (!exp_valid() && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) cmp("result_timeout", n, 0);
        result = m_acc;
        for (int i = 0; i < bp; i++) begin
            if (start_in_done && i == 2) begin
                start = 1; len = 7;
            end
            tick();
            start = 0;
            cmp("hold_out", out, result);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        cmp("busy_after_handshake", busy, 0);
    endtask

    int r;

    initial begin
        rst = 1; start = 0; len = '0; in_valid = 0; out_ready = 0;
        a = 0; b = 0; c = 0; d = 0; e = 0; f = 0; g = 0; h = 0;
        tick();
        tick();
        rst = 0;
        cmp("reset_busy", busy, 0);
        cmp("reset_in_ready", in_ready, 0);
        cmp("reset_out_valid", out_valid, 0);
        cmp("reset_out", out, 0);
        tick();

        // Single chunk with latency pins
        do_job(0, 1, 0, 0, 0, 0, 1, r);
        cmp("single_literal", r, 70);
        cmp("single_out_held_idle", out, 70);

        // Max job, back-to-back
        do_job(15, 2, 0, 0, 0, 0, 0, r);
        cmp("max_literal", r, 14400);

        // Gapped input
        do_job(2, 3, 3, 3, 0, 0, 0, r);
        cmp("gapped_literal", r, 72);

        // Backpressure with an ignored start, then a fresh job
        do_job(1, 1, 0, 0, 5, 1, 0, r);
        cmp("bp_literal", r, 140);
        do_job(0, 1, 0, 0, 0, 0, 0, r);
        cmp("after_bp_literal", r, 70);

        // Reset mid-job after two chunks
        start = 1; len = 3;
        tick();
        start = 0;
        set_ops(2);
        in_valid = 1;
        tick();
        tick();
        in_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        cmp("midrst_busy", busy, 0);
        cmp("midrst_in_ready", in_ready, 0);
        cmp("midrst_out_valid", out_valid, 0);
        cmp("midrst_out", out, 0);
        repeat (6) tick();
        do_job(0, 1, 0, 0, 0, 0, 0, r);
        cmp("after_rst_literal", r, 70);

        // Random jobs
        for (int j = 0; j < 20; j++) begin
            do_job($urandom_range(15, 0), 0, 0, 2, $urandom_range(3, 0), 1, 0, r);
            repeat ($urandom_range(2, 0)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
Sequencer that computes long dot products of up to 2^LEN_W four-lane chunks of 4-bit operands by streaming the chunks through a 4-stage pipelined 4-lane multiply/add-tree datapath. A 4-lane chunk is 4 operand pairs; each lane is one pair. The block accumulates the per-chunk sums into one result. It sits between a vector source (valid/ready chunk stream) and a result consumer (valid/ready), and owns command acceptance, issue control, pipeline drain and result hand-off.

Parameters:
LEN_W, 4, width of the chunk-count field; a job is 1..2^LEN_W chunks.
ACC_W, 10+LEN_W, accumulator/result width; no overflow possible (16 x 900 = 14400 < 2^14).

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  synchronous reset, active-high.
i_start  input  1  job request; accepted only when o_busy=0.
i_len  input  LEN_W  chunk count minus 1; sampled with an accepted i_start.
o_busy  output  1  high from start acceptance until the result handshake completes.
i_in_valid  input  1  chunk present on i_a..i_h.
o_in_ready  output  1  block accepts a chunk this cycle.
i_a,i_b,i_c,i_d  input  4 each  chunk left operands, unsigned.
i_e,i_f,i_g,i_h  input  4 each  chunk right operands, unsigned; lane pairs a*e, b*f, c*g, d*h.
o_out_valid  output  1  result available.
i_out_ready  input  1  consumer takes the result.
o_out  output  ACC_W  dot product, unsigned.

Behaviour:
- Clock/reset: single clock i_clk. Synchronous active-high reset i_rst. At reset: state=IDLE; o_busy=0, o_in_ready=0, o_out_valid=0, o_out=0; accumulator, chunk counter and all pipeline valids/data cleared.
- Reset mid-operation: the same synchronous clear applies. In-flight chunks are discarded and no result is produced.
- FSM states:
  - IDLE: o_busy=0. i_start=1 -> FEED; remaining=i_len; acc=0.
  - FEED: o_in_ready=1. A chunk is accepted when i_in_valid&o_in_ready; it enters the pipe with a valid tag, and the last accepted chunk also carries a last tag. remaining decrements per accepted chunk. Accepting the chunk with remaining=0 -> DRAIN in the same edge.
  - DRAIN: o_in_ready=0. The pipe result with the last tag is accumulated -> DONE on that edge.
  - DONE: o_out_valid=1, o_out=acc held stable. i_out_ready=1 -> IDLE; o_out_valid drops next cycle.
- i_start in any state other than IDLE is ignored; i_len is not re-sampled. A new job can start the cycle after leaving DONE.
- Idle cycles of i_in_valid during FEED are allowed; there is no timeout.
- Pipe latency:
  - A chunk accepted at edge k appears as a valid pipe result after edge k+3.
  - That result is added to acc at edge k+4.
  - For the last chunk, o_out_valid is high from the cycle after edge k+4.
- Throughput: one chunk per cycle. Every valid pipe result is accumulated, each exactly once.
- Width rules: lane products 8b; pair sums 9b; chunk sum 10b; acc ACC_W bits, zero-extended adds, no saturation needed.
- Output hold: o_out and o_out_valid hold while i_out_ready=0. o_out retains the last result in IDLE.

Decomposition:
- Shared package:
  - FSM state typedef {IDLE, FEED, DRAIN, DONE} (2-bit encoding).
  - OPND_W=4 and CHUNK_SUM_W=10 constants.
  - Default LEN_W.
- Sub-module dot4_pipe: the 4-stage datapath (input reg, multiply, pair add, final add) with valid/last tags shifted alongside.
  - Synchronous active-high reset, same i_clk/i_rst naming.
  - Ports: valid_in/last_in, 8 operands, valid_out/last_out, 10b sum.

Test Plan:
- Single chunk: i_len=0; a..d=1,2,3,4, e..h=5,6,7,8, accepted at edge k -> o_out_valid first high after edge k+4, o_out=70; o_busy low the cycle after the i_out_ready handshake.
- Max job: i_len=15; 16 back-to-back chunks, all operands 15 -> o_out=14400; o_in_ready low from the edge accepting chunk 16.
- Gapped input: i_len=2; three chunks each with all lanes 2*3 (sum 24), i_in_valid low 3 cycles between chunks -> o_out=72; no spurious accumulations.
- Backpressure: hold i_out_ready=0 for 5 cycles in DONE -> o_out_valid and o_out stable. i_start pulse during DONE is ignored. After the handshake, a new job (i_len=0, sum 70) starts and returns 70, with acc cleared.
- Reset mid-job: i_len=3; assert i_rst after 2 chunks accepted -> next cycle all outputs 0, state IDLE. A subsequent single-chunk job with sum 70 returns exactly 70.
